// File: rtl/score_text_writer_if.sv
// -----------------------------------------------------------------------------
// score_text_writer_if
// Avalon-MM write-only master bus between the score text writer and the
// character-cell text display.
//   AVM_ADDR        : word address of the character cell
//   AVM_WRITE       : write request
//   AVM_CS          : chip select (mirrors AVM_WRITE)
//   AVM_BYTE_EN     : byte enables (all bytes)
//   AVM_WRITEDATA   : {24'b0, character code}
//   AVM_WAITREQUEST : slave stall; a write is taken on a rising edge with
//                     AVM_WRITE=1 and AVM_WAITREQUEST=0
// -----------------------------------------------------------------------------
interface score_text_writer_if;
  logic [11:0] AVM_ADDR;
  logic        AVM_WRITE;
  logic        AVM_CS;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;

  modport master (
    output AVM_ADDR,
    output AVM_WRITE,
    output AVM_CS,
    output AVM_BYTE_EN,
    output AVM_WRITEDATA,
    input  AVM_WAITREQUEST
  );

  modport slave (
    input  AVM_ADDR,
    input  AVM_WRITE,
    input  AVM_CS,
    input  AVM_BYTE_EN,
    input  AVM_WRITEDATA,
    output AVM_WAITREQUEST
  );
endinterface

// File: rtl/score_text_writer.sv
// -----------------------------------------------------------------------------
// score_text_writer
// Renders one player's score, level and line count as right-justified decimal
// text into a character-cell display over an Avalon-MM master.
// Each field is converted to BCD with a shift-add-3 engine (20 cycles), then
// written as 12 character cells (columns 0..11, units digit at column 11,
// leading zeros and columns 0..4 blank).
//
// Ports:
//   CLK     : clock (also the display's Avalon clock)
//   RESET   : asynchronous active-low reset
//   start   : one-cycle refresh request, honoured only when idle
//   player  : 0 = player 1, 1 = player 2 (sampled with start)
//   score   : 20-bit score (sampled with start)
//   level   : 8-bit level (sampled with start)
//   lines   : 16-bit cleared-line count (sampled with start)
//   busy    : refresh in progress (CONVERT/WRITE)
//   done    : one-cycle pulse when the refresh completes
//   avm     : Avalon-MM master bus (score_text_writer_if.master)
// -----------------------------------------------------------------------------
module score_text_writer #(
  parameter int         BASE_ADDR     = 0,
  parameter int         PLAYER_STRIDE = 236,
  parameter logic [7:0] BLANK_CODE    = 8'h20,
  parameter logic [7:0] ZERO_CODE     = 8'h30
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       start,
  input  logic                       player,
  input  logic [19:0]                score,
  input  logic [7:0]                 level,
  input  logic [15:0]                lines,
  output logic                       busy,
  output logic                       done,
  score_text_writer_if.master        avm
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int          NUM_DIGITS    = 7;
  localparam logic [4:0]  LAST_CONVERT  = 5'd19;
  localparam logic [4:0]  LAST_COLUMN   = 5'd11;
  localparam logic [4:0]  FIRST_DIGIT   = 5'd5;
  localparam logic [1:0]  LAST_FIELD    = 2'd2;
  localparam logic [31:0] FIELD_BASE    = 32'd200;
  localparam logic [31:0] FIELD_WIDTH   = 32'd12;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_player;
  logic [7:0]  r_level;
  logic [15:0] r_lines;
  logic [1:0]  r_field;
  // Shared counter: conversion step in CONVERT, column in WRITE.
  logic [4:0]  r_cnt;
  logic [19:0] r_bin;
  logic [27:0] r_bcd;

  logic        w_write;
  logic        w_accept;
  logic [27:0] w_bcd_adj;
  logic [19:0] w_next_val;
  logic [6:0]  w_show;
  logic [3:0]  w_pos;
  logic [3:0]  w_digit;
  logic [7:0]  w_char;
  logic [31:0] w_addr_full;

  assign w_accept = w_write && !avm.AVM_WAITREQUEST;

  // ---------------------------------------------------------------------------
  // Shift-add-3: every digit >= 5 gets +3 before the whole {bcd,bin} pair
  // shifts left by one. The top digit's carry-out is never needed because a
  // 20-bit value fits in 7 decimal digits.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dabble
      assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                    (r_bcd[gi*4 +: 4] + 4'd3) :
                                    r_bcd[gi*4 +: 4];
      // A digit is printed when it or any more significant digit is nonzero.
      assign w_show[gi] = |r_bcd[27:gi*4];
    end
  endgenerate

  // Value loaded into the converter when the current field's writes finish.
  always_comb begin
    w_next_val = 20'd0;
    case (r_field)
      2'd0:    w_next_val = {12'd0, r_level};
      2'd1:    w_next_val = {4'd0, r_lines};
      default: w_next_val = 20'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Character for the current column. Column c shows decimal position 11-c;
  // columns 0..4 are always blank, position 0 (units) always prints.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pos   = 4'd11 - r_cnt[3:0];
    w_digit = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_pos == 4'(k)) begin
        w_digit = r_bcd[k*4 +: 4];
      end
    end
    w_char = BLANK_CODE;
    if (r_cnt >= FIRST_DIGIT) begin
      if ((w_pos == 4'd0) || w_show[w_pos[2:0]]) begin
        w_char = ZERO_CODE + {4'd0, w_digit};
      end
    end
  end

  // Full-width address; only the low 12 bits reach the bus.
  always_comb begin
    w_addr_full = 32'(BASE_ADDR)
                + (r_player ? 32'(PLAYER_STRIDE) : 32'd0)
                + FIELD_BASE
                + FIELD_WIDTH * {30'd0, r_field}
                + {27'd0, r_cnt};
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        busy = 1'b1;
        if (r_cnt == LAST_CONVERT) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        busy    = 1'b1;
        w_write = 1'b1;
        if (!avm.AVM_WAITREQUEST && (r_cnt == LAST_COLUMN)) begin
          w_state_next = (r_field == LAST_FIELD) ? S_DONE : S_CONVERT;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch, converter and column counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_player <= 1'b0;
      r_level  <= 8'd0;
      r_lines  <= 16'd0;
      r_field  <= 2'd0;
      r_cnt    <= 5'd0;
      r_bin    <= 20'd0;
      r_bcd    <= 28'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_player <= player;
            r_level  <= level;
            r_lines  <= lines;
            r_field  <= 2'd0;
            r_cnt    <= 5'd0;
            r_bin    <= score;
            r_bcd    <= 28'd0;
          end
        end
        S_CONVERT: begin
          r_bcd <= {w_bcd_adj[26:0], r_bin[19]};
          r_bin <= {r_bin[18:0], 1'b0};
          r_cnt <= (r_cnt == LAST_CONVERT) ? 5'd0 : (r_cnt + 5'd1);
        end
        S_WRITE: begin
          // Column only advances on an accepted beat, so a stall simply
          // holds address and data.
          if (w_accept) begin
            if (r_cnt == LAST_COLUMN) begin
              r_cnt <= 5'd0;
              if (r_field != LAST_FIELD) begin
                r_field <= r_field + 2'd1;
                r_bin   <= w_next_val;
                r_bcd   <= 28'd0;
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs: address/data are zero outside WRITE so reset clears them
  // immediately through the state register.
  // ---------------------------------------------------------------------------
  assign avm.AVM_WRITE     = w_write;
  assign avm.AVM_CS        = w_write;
  assign avm.AVM_BYTE_EN   = 4'b1111;
  assign avm.AVM_ADDR      = w_write ? w_addr_full[11:0] : 12'd0;
  assign avm.AVM_WRITEDATA = w_write ? {24'd0, w_char} : 32'd0;

endmodule
